// File: rtl/iterative_divider_if.sv
// Operand/result bundle shared between the execute stage and the iterative divider.
interface iterative_divider_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider (UDIV/SDIV): one quotient bit per cycle on magnitudes,
// signs restored in a final fixup cycle. busy stalls the pipeline for the whole operation.
module iterative_divider #(
  parameter int WIDTH = 64
) (
  input logic               clk,
  input logic               reset_n,
  iterative_divider_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, PREP, DIVIDE, FIXUP, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dnd_raw, dvs_raw, dvs_mag, rem, q;
  logic [WIDTH-1:0] quo_r, rmd_r;
  logic             sop, q_neg, r_neg, dbz_r;
  logic [CNT_W-1:0] cnt;
  logic             busy_c, done_c;

  logic             dnd_neg, dvs_neg, dvs_zero;
  logic [WIDTH-1:0] dnd_abs, dvs_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] trial;
  logic             ge, last;

  // Negation only for SDIV with a negative operand; |MIN| fits as unsigned.
  assign dnd_neg  = sop & dnd_raw[WIDTH-1];
  assign dvs_neg  = sop & dvs_raw[WIDTH-1];
  assign dnd_abs  = dnd_neg ? -dnd_raw : dnd_raw;
  assign dvs_abs  = dvs_neg ? -dvs_raw : dvs_raw;
  assign dvs_zero = (dvs_raw == '0);

  // Shifted partial remainder needs one extra bit once the divisor MSB is set.
  assign rem_sh = {rem, q[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, dvs_mag});
  assign trial  = rem_sh[WIDTH-1:0] - dvs_mag;
  assign last   = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nxt = PREP;
      end
      PREP:   state_nxt = dvs_zero ? DONE : DIVIDE;
      DIVIDE: if (last) state_nxt = FIXUP;
      FIXUP:  state_nxt = DONE;
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dnd_raw <= '0;
      dvs_raw <= '0;
      dvs_mag <= '0;
      rem     <= '0;
      q       <= '0;
      sop     <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      cnt     <= '0;
      quo_r   <= '0;
      rmd_r   <= '0;
      dbz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          dnd_raw <= bus.dividend;
          dvs_raw <= bus.divisor;
          sop     <= bus.signed_op;
        end
        PREP: begin
          q       <= dnd_abs;
          dvs_mag <= dvs_abs;
          rem     <= '0;
          cnt     <= '0;
          q_neg   <= dnd_neg ^ dvs_neg;
          r_neg   <= dnd_neg;
          // Zero divisor skips the loop; remainder is the raw dividend.
          if (dvs_zero) begin
            quo_r <= '0;
            rmd_r <= dnd_raw;
            dbz_r <= 1'b1;
          end
        end
        DIVIDE: begin
          q   <= {q[WIDTH-2:0], ge};
          rem <= ge ? trial : rem_sh[WIDTH-1:0];
          cnt <= cnt + 1'b1;
        end
        FIXUP: begin
          quo_r <= q_neg ? -q : q;
          rmd_r <= r_neg ? -rem : rem;
          dbz_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rmd_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_iterative_divider.sv
// Table-driven bench with a result scoreboard plus hand sequences for busy/abort corners.
module tb_iterative_divider;
  localparam int W = 64;
  localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = '1;
  localparam int NV = 14;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  iterative_divider_if #(.WIDTH(W)) bus();
  iterative_divider #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic         sop;
    logic [W-1:0] dnd, dvs, q, r;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q, r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[NV];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no pending result");
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", bus.quotient, mon_e.q);
        chk("remainder", bus.remainder, mon_e.r);
        chk("div_by_zero", W'(bus.div_by_zero), W'(mon_e.dbz));
      end
    end
  end

  // Ends at the negedge of the done cycle, or after a reset abort at abort_cyc.
  task automatic run_op(input vec_t v, input int exp_lat, input int inj_cyc, input int abort_cyc);
    int   lat;
    bit   busy_ok;
    exp_t e;
    e.q = v.q; e.r = v.r; e.dbz = v.dbz;
    sb.push_back(e);
    bus.signed_op = v.sop;
    bus.dividend  = v.dnd;
    bus.divisor   = v.dvs;
    bus.start     = 1'b1;
    @(posedge clk);
    lat = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == inj_cyc) begin
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 64'd50;
        bus.divisor   = 64'd5;
      end
      if (c == abort_cyc) begin
        reset_n = 1'b0;
        #1;
        chk("abort_busy", W'(bus.busy), '0);
        chk("abort_quotient", bus.quotient, '0);
        chk("abort_remainder", bus.remainder, '0);
        chk("abort_dbz", W'(bus.div_by_zero), '0);
        sb.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) begin
          @(negedge clk);
          chk("abort_no_done", W'(bus.done), '0);
        end
        return;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    chk("latency", W'(lat), W'(exp_lat));
    chk("busy_window", W'(busy_ok), W'(1));
  endtask

  initial begin
    tbl[0]  = '{1'b0, 64'd100,  64'd7,   64'd14,  64'd2,   1'b0};
    tbl[1]  = '{1'b1, -64'd100, 64'd7,   -64'd14, -64'd2,  1'b0};
    tbl[2]  = '{1'b1, 64'd100,  -64'd7,  -64'd14, 64'd2,   1'b0};
    tbl[3]  = '{1'b1, -64'd100, -64'd7,  64'd14,  -64'd2,  1'b0};
    tbl[4]  = '{1'b0, 64'h1234, 64'd0,   64'd0,   64'h1234, 1'b1};
    tbl[5]  = '{1'b1, MIN,      ONES,    MIN,     64'd0,   1'b0};
    tbl[6]  = '{1'b0, ONES,     64'd1,   ONES,    64'd0,   1'b0};
    tbl[7]  = '{1'b0, ONES,     MIN,     64'd1,   64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[8]  = '{1'b1, -64'd5,   64'd0,   64'd0,   -64'd5,  1'b1};
    tbl[9]  = '{1'b0, MIN,      64'd3,   64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0};
    tbl[10] = '{1'b0, 64'd5,    64'd10,  64'd0,   64'd5,   1'b0};
    tbl[11] = '{1'b1, MIN,      64'd2,   64'hC000_0000_0000_0000, 64'd0, 1'b0};
    tbl[12] = '{1'b1, 64'd7,    -64'd1,  -64'd7,  64'd0,   1'b0};
    tbl[13] = '{1'b0, -64'd100, 64'h10,  64'h0FFF_FFFF_FFFF_FFF9, 64'hC, 1'b0};

    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", W'(bus.busy), '0);
    chk("reset_done", W'(bus.done), '0);
    chk("reset_quotient", bus.quotient, '0);
    chk("reset_remainder", bus.remainder, '0);
    chk("reset_dbz", W'(bus.div_by_zero), '0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_op(tbl[i], (tbl[i].dvs == '0) ? 2 : W + 3, 0, 0);
      @(negedge clk);
      chk("hold_done", W'(bus.done), '0);
      chk("hold_busy", W'(bus.busy), '0);
      chk("hold_quotient", bus.quotient, tbl[i].q);
      chk("hold_remainder", bus.remainder, tbl[i].r);
    end

    // start while busy must not disturb the running operation
    run_op(tbl[0], W + 3, 10, 0);
    @(negedge clk);
    chk("ignored_start_q", bus.quotient, tbl[0].q);
    chk("ignored_start_busy", W'(bus.busy), '0);

    // start in the DONE cycle is dropped, start one cycle later is taken
    run_op(tbl[1], W + 3, 0, 0);
    bus.start     = 1'b1;
    bus.signed_op = tbl[2].sop;
    bus.dividend  = tbl[2].dnd;
    bus.divisor   = tbl[2].dvs;
    @(negedge clk);
    chk("done_cycle_start_busy", W'(bus.busy), '0);
    run_op(tbl[2], W + 3, 0, 0);
    @(negedge clk);

    // reset mid-operation, then a clean operation afterwards
    run_op(tbl[0], W + 3, 0, 30);
    run_op(tbl[3], W + 3, 0, 0);
    @(negedge clk);
    chk("post_abort_q", bus.quotient, tbl[3].q);

    chk("sb_drain", W'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
